// File: rtl/bcd_timer_core.sv
// bcd_timer_core: BCD stopwatch/timer with start/pause, clear/reload, lap hold and done flag.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   tick         one-cycle count strobe
//   mode         0 = count down from preset, 1 = count up from 0 (sampled in IDLE)
//   start        toggles start/pause
//   clr          returns to IDLE and reloads
//   lap          toggles lap hold (RUN/PAUSE only)
//   preset       BCD start value for down mode
//   digits       BCD value for display (lap snapshot while lap_active)
//   running      high in RUN
//   done         high in DONE
//   lap_active   display frozen on the lap snapshot
module bcd_timer_core #(
   parameter int                  DIGITS    = 2,
   parameter logic [DIGITS-1:0]   SEXA_MASK = '0,
   parameter logic [4*DIGITS-1:0] UP_LIMIT  = '1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick,
   input  logic                  mode,
   input  logic                  start,
   input  logic                  clr,
   input  logic                  lap,
   input  logic [4*DIGITS-1:0]   preset,
   output logic [4*DIGITS-1:0]   digits,
   output logic                  running,
   output logic                  done,
   output logic                  lap_active
);
   localparam int W = 4*DIGITS;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   state_t state_q, state_d;
   logic [W-1:0] count_q, count_d, snap_q, snap_d, load, up_lim, term, stepped;
   logic lap_q, lap_d, dir_q, dir_d;

   function automatic logic [3:0] dmax(input int i);
      return SEXA_MASK[i] ? 4'd5 : 4'd9;
   endfunction

   // Out-of-range digits load as that digit's max; the default all-ones
   // UP_LIMIT therefore becomes "every digit at max".
   function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++)
         if (v[4*i+:4] > dmax(i)) r[4*i+:4] = dmax(i);
      return r;
   endfunction

   // Ripple carry (up) or borrow (down) through all digits in one cycle.
   function automatic logic [W-1:0] step_fn(input logic [W-1:0] v, input logic up);
      logic [W-1:0] r;
      logic c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++)
         if (c) begin
            if (up) begin
               if (r[4*i+:4] >= dmax(i)) r[4*i+:4] = 4'd0;
               else begin
                  r[4*i+:4] = r[4*i+:4] + 4'd1;
                  c = 1'b0;
               end
            end else begin
               if (r[4*i+:4] == 4'd0) r[4*i+:4] = dmax(i);
               else begin
                  r[4*i+:4] = r[4*i+:4] - 4'd1;
                  c = 1'b0;
               end
            end
         end
      return r;
   endfunction

   assign up_lim  = clamp(UP_LIMIT);
   assign load    = mode ? {W{1'b0}} : clamp(preset);
   assign term    = dir_q ? up_lim : {W{1'b0}};
   assign stepped = step_fn(count_q, dir_q);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      snap_d  = snap_q;
      lap_d   = lap_q;
      dir_d   = dir_q;
      if (clr) begin
         state_d = IDLE;
         count_d = load;
         lap_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               count_d = load;
               if (start) begin
                  dir_d   = mode;
                  state_d = (load == (mode ? up_lim : {W{1'b0}})) ? DONE : RUN;
               end
            end
            RUN, PAUSE: begin
               // Snapshot takes the pre-tick count even when a tick lands in the same cycle.
               if (lap) begin
                  snap_d = lap_q ? snap_q : count_q;
                  lap_d  = !lap_q;
               end
               if (start) state_d = (state_q == RUN) ? PAUSE : RUN;
               else if (tick && state_q == RUN) begin
                  count_d = stepped;
                  if (stepped == term) begin
                     state_d = DONE;
                     lap_d   = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         snap_q  <= '0;
         lap_q   <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         snap_q  <= snap_d;
         lap_q   <= lap_d;
         dir_q   <= dir_d;
      end
   end

   assign digits     = lap_q ? snap_q : count_q;
   assign running    = (state_q == RUN);
   assign done       = (state_q == DONE);
   assign lap_active = lap_q;
endmodule

// File: tb/tb_bcd_timer_core.sv
// tb_bcd_timer_core: directed and randomized checks of bcd_timer_core against an integer reference model.
module tb_bcd_timer_core;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, tick, start, clr, lap, mode;
   logic [7:0] preset, digits;
   logic running, done, lap_active;

   logic s_tick, s_start, s_clr, s_lap, s_mode;
   logic [15:0] s_preset, s_digits;
   logic s_running, s_done, s_lap_active;

   bcd_timer_core u_dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode), .start(start), .clr(clr),
      .lap(lap), .preset(preset), .digits(digits), .running(running), .done(done),
      .lap_active(lap_active)
   );

   bcd_timer_core #(.DIGITS(4), .SEXA_MASK(4'b0010), .UP_LIMIT(16'h0100)) u_sexa (
      .clk(clk), .rst_n(rst_n), .tick(s_tick), .mode(s_mode), .start(s_start), .clr(s_clr),
      .lap(s_lap), .preset(s_preset), .digits(s_digits), .running(s_running), .done(s_done),
      .lap_active(s_lap_active)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: count held as a plain integer 0..99; states 0 idle, 1 run, 2 pause, 3 done.
   int m_st, m_val, m_snap, m_dir;
   bit m_lap;

   function automatic int nib(input logic [3:0] n);
      return (n > 4'd9) ? 9 : int'(n);
   endfunction

   function automatic logic [7:0] int2bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      m_st = 0; m_val = 0; m_snap = 0; m_dir = 0; m_lap = 0;
   endtask

   task automatic model_edge();
      int ld, old, term;
      bit fin;
      ld   = mode ? 0 : nib(preset[7:4]) * 10 + nib(preset[3:0]);
      term = m_dir ? 99 : 0;
      old  = m_val;
      fin  = 0;
      if (clr) begin
         m_st = 0; m_val = ld; m_lap = 0;
      end else if (m_st == 0) begin
         m_val = ld;
         if (start) begin
            m_dir = int'(mode);
            m_st  = (ld == (mode ? 99 : 0)) ? 3 : 1;
         end
      end else if (m_st == 1 || m_st == 2) begin
         if (start) m_st = (m_st == 1) ? 2 : 1;
         else if (tick && m_st == 1) begin
            m_val = m_dir ? m_val + 1 : m_val - 1;
            if (m_val == term) begin
               m_st = 3;
               fin  = 1;
            end
         end
         if (fin) m_lap = 0;
         else if (lap) begin
            if (!m_lap) begin
               m_snap = old;
               m_lap  = 1;
            end else m_lap = 0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      check("digits", 16'(digits), 16'(int2bcd(m_lap ? m_snap : m_val)));
      check("running", 16'(running), 16'(m_st == 1));
      check("done", 16'(done), 16'(m_st == 3));
      check("lap_active", 16'(lap_active), 16'(m_lap));
   endtask

   task automatic step(input bit t, input bit s, input bit c, input bit l);
      tick = t; start = s; clr = c; lap = l;
      @(posedge clk);
      model_edge();
      #1;
      check_model();
      tick = 0; start = 0; clr = 0; lap = 0;
   endtask

   initial begin
      rst_n = 1; tick = 0; start = 0; clr = 0; lap = 0; mode = 0; preset = 8'h25;
      s_tick = 0; s_start = 0; s_clr = 0; s_lap = 0; s_mode = 1; s_preset = 16'h0000;
      #1 rst_n = 0;
      #1;
      model_reset();
      check("reset_digits", 16'(digits), 16'h0000);
      check("reset_flags", {13'd0, running, done, lap_active}, 16'h0000);
      check("reset_sexa", s_digits, 16'h0000);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1;
      step(0, 0, 0, 0);
      check("reset_load", 16'(digits), 16'h0025);

      // Sexagesimal up count on the 4-digit instance
      s_start = 1;
      step(0, 0, 0, 0);
      s_start = 0;
      check("sexa_running", 16'(s_running), 16'h0001);
      s_tick = 1;
      repeat (10) step(0, 0, 0, 0);
      check("sexa_10", s_digits, 16'h0010);
      repeat (49) step(0, 0, 0, 0);
      check("sexa_59", s_digits, 16'h0059);
      check("sexa_not_done", 16'(s_done), 16'h0000);
      step(0, 0, 0, 0);
      s_tick = 0;
      check("sexa_100", s_digits, 16'h0100);
      check("sexa_done", {14'd0, s_running, s_done}, 16'h0001);

      // Full countdown
      step(0, 1, 0, 0);
      check("cd_running", 16'(running), 16'h0001);
      repeat (15) step(1, 0, 0, 0);
      check("cd_10", 16'(digits), 16'h0010);
      step(1, 0, 0, 0);
      check("cd_09", 16'(digits), 16'h0009);
      repeat (9) step(1, 0, 0, 0);
      check("cd_00", 16'(digits), 16'h0000);
      check("cd_done", {14'd0, running, done}, 16'h0001);
      step(1, 1, 0, 0);
      check("done_hold", {7'd0, digits, running, done}, 16'h0001);
      step(0, 0, 1, 0);
      check("clr_reload", 16'(digits), 16'h0025);

      // Pause and simultaneous start+tick
      step(0, 1, 0, 0);
      repeat (3) step(1, 0, 0, 0);
      check("pause_22", 16'(digits), 16'h0022);
      step(1, 1, 0, 0);
      check("pause_same", 16'(digits), 16'h0022);
      repeat (5) step(1, 0, 0, 0);
      check("pause_hold", 16'(digits), 16'h0022);
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      check("resume_21", 16'(digits), 16'h0021);

      // Lap hold
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      repeat (4) step(1, 0, 0, 0);
      check("lap_frozen", 16'(digits), 16'h0020);
      check("lap_active", 16'(lap_active), 16'h0001);
      step(0, 0, 0, 1);
      check("lap_release", 16'(digits), 16'h0016);
      step(0, 0, 1, 0);

      // Edge cases
      preset = 8'h00;
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      check("zero_preset_done", 16'(done), 16'h0001);
      step(0, 0, 1, 0);
      preset = 8'hCC;
      step(0, 0, 0, 0);
      check("sanitise_99", 16'(digits), 16'h0099);
      preset = 8'h25;
      step(0, 0, 0, 0);
      step(0, 1, 1, 0);
      check("clr_start_idle", {14'd0, running, done}, 16'h0000);
      check("clr_start_digits", 16'(digits), 16'h0025);

      // Asynchronous reset in the middle of a count
      step(0, 1, 0, 0);
      repeat (5) step(1, 0, 0, 0);
      @(negedge clk);
      rst_n = 0;
      #1;
      model_reset();
      check("async_digits", 16'(digits), 16'h0000);
      check("async_flags", {13'd0, running, done, lap_active}, 16'h0000);
      @(posedge clk);
      #1 rst_n = 1;

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 31) == 0) preset = 8'($urandom);
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         step(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
              $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/bcd_timer_core.md
# bcd_timer_core

Parametrised stopwatch/timer core that counts N BCD digits up or down on a one-cycle count strobe. Includes start/pause control, clear/reload, lap hold and a terminal-count flag. It sits between the push-button one-pulse stage and `scan_ctl`/`display`, and replaces the fixed two-digit down counter plus its control FSM. All logic runs on the system clock; the count rate comes from the `tick` enable, not from a divided clock.

## Interface
- `DIGITS`, 2: number of BCD digits; digit 0 is least significant.
- `SEXA_MASK`, {DIGITS{1'b0}}: bit i = 1 makes digit i count 0–5 (minutes:seconds style); bit i = 0 means 0–9.
- `UP_LIMIT`, all digits at max: BCD terminal value in up mode.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  one-cycle count strobe, for example 1 Hz.
- `mode`  in  1  0 = count down from `preset`, 1 = count up from 0. Used only in IDLE.
- `start`  in  1  one-cycle pulse that toggles start/pause.
- `clr`  in  1  one-cycle pulse that returns the core to IDLE and reloads.
- `lap`  in  1  one-cycle pulse that toggles lap hold.
- `preset`  in  4*DIGITS  BCD start value for down mode.
- `digits`  out  4*DIGITS  BCD value for display.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `lap_active`  out  1  display is frozen on the lap snapshot.

## Operation
- **Reset:** state IDLE, count = 0, snapshot = 0, `digits` = 0, `running`/`done`/`lap_active` = 0.
- **States and transitions:**
  - **IDLE:** every cycle, count <= load value. Load value is `preset` when `mode` = 0 and 0 when `mode` = 1.
    - `start` latches `mode`, then goes to RUN.
    - In down mode with load value 0, `start` goes straight to DONE.
    - `tick` and `lap` are ignored.
  - **RUN:** each `tick` steps count by one in the latched direction.
    - `start` goes to PAUSE.
    - When the stepped result equals the terminal value (0 in down mode, `UP_LIMIT` in up mode), go to DONE.
  - **PAUSE:** count holds and `tick` is ignored. `start` goes to RUN.
  - **DONE:** count holds at the terminal value. `start`, `tick` and `lap` are ignored.
  - **`clr` in any state:** go to IDLE and clear `lap_active`.
- **Digit arithmetic:** ripple carry/borrow across digits within a single cycle.
  - Up: a digit at its max (9, or 5 when its mask bit is set) wraps to 0 and carries into the next digit.
  - Down: a digit at 0 wraps to its max and borrows from the next digit.
  - Up mode never passes `UP_LIMIT`.
- **Preset sanitising:** any preset digit above its max (for example 4'hC, or 7 on a base-6 digit) loads as that digit's max.
- **Lap hold (RUN and PAUSE only):**
  - `lap` with `lap_active` = 0 captures count into the snapshot and sets `lap_active`.
  - `lap` with `lap_active` = 1 clears `lap_active`.
  - `digits` shows the snapshot while `lap_active` = 1, otherwise the live count.
  - Counting continues while the lap hold is active.
- **Entering DONE:** clears `lap_active`, so the terminal value is always displayed.
- **Simultaneous events:**
  - `clr` takes priority over everything.
  - `start` with `tick` in IDLE: start the run; that tick does not count.
  - `start` with `tick` in RUN: pause; that tick does not count.
  - `lap` with `tick` in RUN: the snapshot takes the pre-tick value and count steps.
- **Mode:** changing `mode` outside IDLE has no effect.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- A `tick` in cycle n updates `digits` in cycle n+1.
- `done` rises in the same cycle that `digits` shows the terminal value, and `running` falls in that same cycle.
- `start`, `clr` and `lap` take effect on the next edge: state and flags update one cycle after the pulse.
- In IDLE, a change on `preset` or `mode` appears on `digits` one cycle later.
- Asynchronous `rst_n` assertion mid-count forces all reset values immediately. Release is synchronous to `clk` in the surrounding design.

## Test plan
- **Reset and load:** `DIGITS`=2, `preset`=8'h25, `mode`=0. Assert `rst_n`=0 → `digits`=8'h00 and all flags 0. Release → `digits`=8'h25 one cycle later.
- **Full countdown:** `start`, then 25 ticks → `digits` steps 24, 23, … and 10 → 09 on the borrow. After tick 25: `digits`=8'h00, `done`=1, `running`=0. A further `tick` or `start` leaves the outputs unchanged. `clr` → IDLE, `digits`=8'h25.
- **Pause and simultaneous events:** `start`, 3 ticks → 8'h22. `start` together with a `tick` → PAUSE, still 22. Five more ticks → still 22. `start`, then one tick → 8'h21.
- **Lap:** pause at 8'h20 and resume. `lap` pulse, then 4 ticks → `digits`=8'h20 and `lap_active`=1. Second `lap` pulse → `digits`=8'h16.
- **Sexagesimal up count:** `DIGITS`=4, `SEXA_MASK`=4'b0010, `UP_LIMIT`=16'h0100, `mode`=1. `start`, 59 ticks → 16'h0059. One more tick → 16'h0100 with `done`=1.
- **Edge cases:**
  - `preset`=8'h00 in down mode, then `start` → `done`=1 the next cycle.
  - `preset`=8'hCC → IDLE `digits`=8'h99.
  - `clr` in the same cycle as `start` → stays in IDLE.
